// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types, parity encodings and divisor helper for the UART receive decoder
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_WAIT_HI
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded clocks-per-bit.
  function automatic int div_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead FIFO holding decoded frames; head reads as zero when empty
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == FULL_LVL);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the slot a same-cycle push needs when full.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_decoder.sv
// rtl/uart_rx_decoder.sv - UART receive decoder with framing/parity checks and buffered output
// Optional feature: UART_RX_PARITY_EN enables the parity bit and parity_err_o.
module uart_rx_decoder
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        rx_i,
  output logic [DATA_BITS-1:0]        data_o,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        overflow_o,
  input  logic                        clr_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int DIV = div_calc(CLK_FREQ_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
  localparam int EW  = DATA_BITS + 2;
`else
  localparam int EW  = DATA_BITS + 1;
`endif

  localparam logic [CW-1:0] HALF_LD   = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LD   = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (DIV < 8) begin : g_div_chk
    $error("uart_rx_decoder: clocks per bit must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_rx_decoder: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_decoder: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 r_sync1;
  logic                 r_rxs;
  logic                 r_rxs_d;
  rx_state_e            r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bits;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr;
`ifdef UART_RX_PARITY_EN
  logic                 r_perr;
`endif
  logic                 r_push;
  logic [EW-1:0]        r_entry;
  logic                 r_overflow;

  logic                 w_tc;
  logic [EW-1:0]        w_rdata;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_drop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  assign w_tc = (r_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
      r_push  <= 1'b0;
      r_entry <= '0;
    end else begin
      r_push <= 1'b0;
      if (!w_tc) r_cnt <= r_cnt - CW'(1);
      case (r_state)
        ST_IDLE: begin
          if (r_rxs_d && !r_rxs) begin
            r_cnt   <= HALF_LD;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tc) begin
            if (r_rxs) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt   <= FULL_LD;
              r_bits  <= '0;
              r_ferr  <= 1'b0;
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_tc) begin
            r_cnt   <= FULL_LD;
            r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
            if (r_bits == DATA_LAST) begin
              r_bits  <= '0;
`ifdef UART_RX_PARITY_EN
              r_state <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bits <= r_bits + BW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PAR: begin
          if (w_tc) begin
            r_cnt   <= FULL_LD;
            r_perr  <= ((^r_shift) ^ r_rxs) != (PARITY == PAR_ODD);
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_tc) begin
            if (r_bits == STOP_LAST) begin
              r_push  <= 1'b1;
`ifdef UART_RX_PARITY_EN
              r_entry <= {r_ferr | ~r_rxs, r_perr, r_shift};
`else
              r_entry <= {r_ferr | ~r_rxs, r_shift};
`endif
              // A line still low here is a break; hold off start detection until it releases.
              r_state <= r_rxs ? ST_IDLE : ST_WAIT_HI;
            end else begin
              r_ferr <= r_ferr | ~r_rxs;
              r_bits <= r_bits + BW'(1);
              r_cnt  <= FULL_LD;
            end
          end
        end
        ST_WAIT_HI: begin
          if (r_rxs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_pop  = ready_i && !w_empty;
  assign w_drop = r_push && w_full && !w_pop;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_i) begin
      r_overflow <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_push  (r_push),
    .i_wdata (r_entry),
    .i_pop   (ready_i),
    .o_rdata (w_rdata),
    .o_level (level_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign valid_o     = !w_empty;
  assign data_o      = w_rdata[DATA_BITS-1:0];
  assign frame_err_o = w_rdata[EW-1];
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = w_rdata[DATA_BITS];
`else
  assign parity_err_o = 1'b0;
`endif
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_uart_rx_decoder.sv
// tb/tb_uart_rx_decoder.sv - scoreboard bench for uart_rx_decoder at 16 clocks per bit, 8E1
// Parity-specific vectors run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_decoder;

  localparam int CLK_HZ = 16_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int DIV    = 16;
  localparam int DBITS  = 8;
  localparam int SBITS  = 1;
  localparam int DEPTH  = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NSAMP = DBITS + P + SBITS;
  localparam int LAT   = 2 + DIV / 2 + NSAMP * DIV + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx = 1'b1;
  logic             ready = 1'b1;
  logic             clr = 1'b0;
  logic [DBITS-1:0] data;
  logic             fe;
  logic             pe;
  logic             valid;
  logic             ovf;
  logic [4:0]       level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [9:0] sb[$];

  uart_rx_decoder #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD        (BAUD),
    .DATA_BITS   (DBITS),
    .PARITY      (2),
    .STOP_BITS   (SBITS),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .rx_i         (rx),
    .data_o       (data),
    .frame_err_o  (fe),
    .parity_err_o (pe),
    .valid_o      (valid),
    .ready_i      (ready),
    .overflow_o   (ovf),
    .clr_i        (clr),
    .level_o      (level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head entry is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: actual=0x%0h required=none", {fe, pe, data});
      end else begin
        check("sb_entry", {22'd0, fe, pe, data}, {22'd0, sb.pop_front()});
      end
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < DBITS; i++) drive_bit(d[i]);
    if (P != 0) drive_bit(par_bit);
    for (int i = 0; i < SBITS; i++) drive_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    sb.push_back({2'b00, d});
    send_frame(d, ^d);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 4000; k++) begin
      if (sb.size() == 0 && !valid) break;
      @(negedge clk);
    end
    check(name, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int rise;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", ovf, 0);
    check("rst_data", data, 0);
    check("rst_flags", {fe, pe}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    // First frame latency and single-cycle valid with ready held high.
    t0 = cyc + 1;
    rise = -1;
    fork
      send_byte(8'h41);
      begin
        for (int k = 0; k < LAT + 40; k++) begin
          @(negedge clk);
          if (valid) begin
            rise = cyc - t0;
            break;
          end
        end
        check("valid_latency", rise, LAT);
        @(negedge clk);
        check("valid_one_cycle", valid, 0);
      end
    join
    drain("drain_41");

    // Half-bit glitch is rejected.
    rx = 1'b0;
    repeat (DIV / 2) @(posedge clk);
    #1;
    idle(2 * DIV);
    check("glitch_level", level, 0);
    send_byte(8'h55);
    drain("drain_55");

`ifdef UART_RX_PARITY_EN
    sb.push_back({1'b0, 1'b1, 8'h07});
    send_frame(8'h07, 1'b0);
    drain("drain_parity");
`endif

    // Break: two frame times low gives exactly one framing-error entry.
    sb.push_back({1'b1, 1'b0, 8'h00});
    rx = 1'b0;
    repeat (2 * (1 + NSAMP) * DIV) @(posedge clk);
    #1;
    check("break_level", level, 0);
    check("break_sb", sb.size(), 0);
    idle(2 * DIV);
    check("break_release", level, 0);
    send_byte(8'h33);
    drain("drain_33");

    // Overflow: 17 frames into a 16-deep FIFO with no reader.
    ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) sb.push_back({2'b00, 8'(i)});
      send_frame(8'(i), ^(8'(i)));
    end
    idle(DIV);
    check("ovf_level", level, 16);
    check("ovf_flag", ovf, 1);
    ready = 1'b1;
    drain("drain_ovf");
    check("ovf_sticky", ovf, 1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    check("ovf_clear", ovf, 0);
    @(posedge clk);
    #1;

    // Reset in the middle of a frame with one entry already buffered.
    ready = 1'b0;
    send_byte(8'hA5);
    idle(DIV);
    check("pre_rst_level", level, 1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_data", {fe, pe, data}, 0);
    check("mid_rst_ovf", ovf, 0);
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready = 1'b1;
    idle(2 * DIV);
    send_byte(8'h3C);
    drain("drain_3c");

    check("final_level", level, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
